// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, branch resolution via a programmable jump-target LUT,
// and the Start/Done handshake. Define FETCH_CYCLE_COUNT_EN to enable the RUN-cycle counter.
module fetch_unit #(
  parameter int unsigned     PC_W       = 10,
  parameter int unsigned     LUT_DEPTH  = 64,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic            Jen,
  input  logic [7:0]      Jptr,
  input  logic            Zero,
  input  logic            Done_in,
  input  logic            LutWe,
  input  logic [5:0]      LutAddr,
  input  logic [PC_W-1:0] LutData,
  output logic [PC_W-1:0] Prog_ctr,
  output logic            Running,
  output logic            Done,
  output logic [15:0]     Cycles
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned CYC_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            running_q, running_d;
  logic            done_q, done_d;

  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] lut_rd_c;
  logic            lut_we_c;
  logic            jptr_unused_c;

  // Upper pointer bits carry no meaning for this LUT depth.
  assign jptr_unused_c = ^Jptr[7:IDX_W];

  assign lut_rd_c = lut_q[Jptr[IDX_W-1:0]];
  assign lut_we_c = LutWe && (state_q != S_RUN);

  // Jump-target table: cleared by reset, writable only outside RUN.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(LUT_DEPTH); i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we_c) begin
      lut_q[LutAddr] <= LutData;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_d = START_ADDR;
        if (Start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (Done_in) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (Jen && Zero) begin
          pc_d = lut_rd_c;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      S_HALT: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START_ADDR;
      end
    endcase
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= START_ADDR;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign Prog_ctr = pc_q;
  assign Running  = running_q;
  assign Done     = done_q;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CYC_W-1:0] cycles_q, cycles_d;

  // Restart on RUN entry, count each RUN edge, saturate at all-ones.
  always_comb begin
    cycles_d = cycles_q;
    if ((state_q != S_RUN) && (state_d == S_RUN)) begin
      cycles_d = '0;
    end else if ((state_q == S_RUN) && (cycles_q != {CYC_W{1'b1}})) begin
      cycles_d = cycles_q + CYC_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign Cycles = cycles_q;
`else
  assign Cycles = CYC_W'(0);
`endif

endmodule
